tone_write_scheduler: RTL and testbench

Front-end controller for the 4-channel tone generator datapath. It owns the free-running 10-bit master sequence counter that drives the datapath slot schedule. It assembles 3-byte register-write commands from the 8-bit host byte bus and queues them in a small FIFO. It issues each write to the datapath register port only inside the safe window, so configuration never lands while phase accumulation, wave sampling or mixing is in progress.

---
 rtl/tone_write_scheduler_pkg.sv | 18 +
 rtl/tone_write_scheduler_cmd_fifo.sv | 49 ++++
 rtl/tone_write_scheduler.sv | 132 +++++++++++++
 tb/tb_tone_write_scheduler.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/tone_write_scheduler_pkg.sv
// tone_ctrl_pkg: shared constants, address map and command types for the tone write scheduler
package tone_ctrl_pkg;
    localparam logic [9:0] SAFE_START = 10'd12;
    localparam logic [7:0] SLOT_ACCUM = 8'd0;
    localparam logic [7:0] SLOT_SAMPLE = 8'd1;
    localparam logic [7:0] SLOT_MIX = 8'd2;
    localparam logic [3:0] ADDR_PHASE_BASE = 4'h0;
    localparam logic [3:0] ADDR_VOLUME_BASE = 4'h4;
    localparam logic [3:0] ADDR_WAVE_TYPE = 4'h8;
    typedef enum logic [1:0] {ST_IDLE, ST_LO, ST_HI} asm_state_e;
    typedef struct packed {
        logic [3:0] addr;
        logic [15:0] data;
    } cmd_t;
    function automatic logic in_window(input logic [9:0] count);
        return count >= SAFE_START;
    endfunction
endpackage

// File: rtl/tone_write_scheduler_cmd_fifo.sv
// cmd_fifo: synchronous power-of-two FIFO holding queued register write commands
module cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 20,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk_in,
    input  logic             reset_in,
    input  logic             push_in,
    input  logic             pop_in,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             full_out,
    output logic             empty_out,
    output logic [AW:0]      level_out
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0] level_q, level_d;
    logic do_push, do_pop;
    assign full_out = level_q == (AW+1)'(DEPTH);
    assign empty_out = level_q == '0;
    assign level_out = level_q;
    assign data_out = mem_q[rd_ptr_q];
    // pointer and occupancy update; pointers wrap naturally since DEPTH is a power of two
    always_comb begin
        do_push = push_in && !full_out;
        do_pop = pop_in && !empty_out;
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        level_d = level_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
    // control state registers
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q <= level_d;
        end
    end
    // storage needs no reset: only slots below the level are ever read
    always_ff @(posedge clk_in) begin
        if (do_push) mem_q[wr_ptr_q] <= data_in;
    end
endmodule

// File: rtl/tone_write_scheduler.sv
// tone_write_scheduler: slot counter, 3-byte command assembler and safe-window write issue; CMD_TIMEOUT_EN adds a partial-command timeout
module tone_write_scheduler
    import tone_ctrl_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT_CYCLES = 255,
    localparam int LW = $clog2(FIFO_DEPTH) + 1
) (
    input  logic          clk_in,
    input  logic          reset_in,
    input  logic [7:0]    bus_data_in,
    input  logic          bus_valid_in,
    output logic          bus_ready_out,
    output logic [9:0]    master_count_out,
    output logic [15:0]   wr_data_out,
    output logic [3:0]    wr_addr_out,
    output logic          wr_valid_out,
    output logic          err_out,
    output logic [LW-1:0] fifo_level_out
);
    logic [9:0] count_q, count_d;
    asm_state_e state_q, state_d;
    logic [3:0] addr_q, addr_d;
    logic bad_q, bad_d;
    logic [7:0] lo_q, lo_d;
    logic push_q, push_d;
    cmd_t cmd_q, cmd_d;
    logic err_q, err_d;
    logic wr_valid_q, wr_valid_d;
    logic [3:0] wr_addr_q, wr_addr_d;
    logic [15:0] wr_data_q, wr_data_d;
    cmd_t head;
    logic fifo_full, fifo_empty, accept, pop;
`ifdef CMD_TIMEOUT_EN
    localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
    logic [IW-1:0] idle_q, idle_d;
`endif
    assign bus_ready_out = !fifo_full;
    assign master_count_out = count_q;
    assign wr_valid_out = wr_valid_q;
    assign wr_addr_out = wr_addr_q;
    assign wr_data_out = wr_data_q;
    assign err_out = err_q;
    cmd_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(20)) u_fifo (
        .clk_in(clk_in),
        .reset_in(reset_in),
        .push_in(push_q),
        .pop_in(pop),
        .data_in(cmd_q),
        .data_out(head),
        .full_out(fifo_full),
        .empty_out(fifo_empty),
        .level_out(fifo_level_out)
    );
    // assembler next state, one-cycle delayed push, and pop gated on the upcoming slot
    always_comb begin
        accept = bus_valid_in && !fifo_full;
        count_d = count_q + 10'd1;
        pop = !fifo_empty && in_window(count_d);
        state_d = state_q;
        addr_d = addr_q;
        bad_d = bad_q;
        lo_d = lo_q;
        push_d = 1'b0;
        cmd_d = cmd_q;
        err_d = err_q;
        if (accept) begin
            case (state_q)
                ST_IDLE: begin
                    addr_d = bus_data_in[3:0];
                    bad_d = |bus_data_in[7:4];
                    err_d = err_q || (|bus_data_in[7:4]);
                    state_d = ST_LO;
                end
                ST_LO: begin
                    lo_d = bus_data_in;
                    state_d = ST_HI;
                end
                default: begin
                    push_d = !bad_q;
                    cmd_d = '{addr: addr_q, data: {bus_data_in, lo_q}};
                    state_d = ST_IDLE;
                end
            endcase
        end
`ifdef CMD_TIMEOUT_EN
        idle_d = (accept || state_q == ST_IDLE) ? '0 : fifo_full ? idle_q : idle_q + 1'b1;
        if (!accept && state_q != ST_IDLE && !fifo_full && int'(idle_q) + 1 >= TIMEOUT_CYCLES) begin
            state_d = ST_IDLE;
            err_d = 1'b1;
            idle_d = '0;
        end
`endif
        wr_valid_d = pop;
        wr_addr_d = pop ? head.addr : wr_addr_q;
        wr_data_d = pop ? head.data : wr_data_q;
    end
    // all scheduler state, cleared together so reset drops any partial or queued command
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            count_q <= '0;
            state_q <= ST_IDLE;
            addr_q <= '0;
            bad_q <= 1'b0;
            lo_q <= '0;
            push_q <= 1'b0;
            cmd_q <= '0;
            err_q <= 1'b0;
            wr_valid_q <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
`ifdef CMD_TIMEOUT_EN
            idle_q <= '0;
`endif
        end else begin
            count_q <= count_d;
            state_q <= state_d;
            addr_q <= addr_d;
            bad_q <= bad_d;
            lo_q <= lo_d;
            push_q <= push_d;
            cmd_q <= cmd_d;
            err_q <= err_d;
            wr_valid_q <= wr_valid_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
`ifdef CMD_TIMEOUT_EN
            idle_q <= idle_d;
`endif
        end
    end
endmodule

// File: tb/tb_tone_write_scheduler.sv
// tb_tone_write_scheduler: scoreboard bench for tone_write_scheduler
module tb_tone_write_scheduler;
    import tone_ctrl_pkg::*;
    localparam int DEPTH = 4;
    logic clk_in = 1'b0;
    logic reset_in = 1'b1;
    logic [7:0] bus_data_in = 8'h00;
    logic bus_valid_in = 1'b0;
    logic bus_ready_out;
    logic [9:0] master_count_out;
    logic [15:0] wr_data_out;
    logic [3:0] wr_addr_out;
    logic wr_valid_out;
    logic err_out;
    logic [$clog2(DEPTH):0] fifo_level_out;
    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int n_wr = 0;
    int nw0 = 0;
    int last_wr_cyc = -1;
    int last_wr_cnt = -1;
    int acc_cyc = 0;
    int max_level = 0;
    bit saw_stall = 1'b0;
    cmd_t sb[$];
    int wr_cnts[$];
    cmd_t exp_cmd;

    tone_write_scheduler #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(255)) dut (
        .clk_in(clk_in),
        .reset_in(reset_in),
        .bus_data_in(bus_data_in),
        .bus_valid_in(bus_valid_in),
        .bus_ready_out(bus_ready_out),
        .master_count_out(master_count_out),
        .wr_data_out(wr_data_out),
        .wr_addr_out(wr_addr_out),
        .wr_valid_out(wr_valid_out),
        .err_out(err_out),
        .fifo_level_out(fifo_level_out)
    );

    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic chk(input string tag, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk_in) begin
        if (!reset_in) begin
            if (!bus_ready_out) saw_stall = 1'b1;
            if (int'(fifo_level_out) > max_level) max_level = int'(fifo_level_out);
            if (wr_valid_out) begin
                n_wr++;
                last_wr_cyc = cyc;
                last_wr_cnt = int'(master_count_out);
                wr_cnts.push_back(int'(master_count_out));
                chk("wr_window", int'(master_count_out >= 10'd12), 1);
                if (sb.size() == 0) chk("unexpected_wr", int'(wr_valid_out), 0);
                else begin
                    exp_cmd = sb.pop_front();
                    chk("wr_addr", int'(wr_addr_out), int'(exp_cmd.addr));
                    chk("wr_data", int'(wr_data_out), int'(exp_cmd.data));
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        bit r;
        int n;
        n = 0;
        bus_data_in = b;
        bus_valid_in = 1'b1;
        do begin
            @(negedge clk_in);
            r = bus_ready_out;
            @(posedge clk_in);
            #1;
            n++;
        end while (!r && n < 2000);
        chk("byte_accept", int'(r), 1);
        acc_cyc = cyc;
        bus_valid_in = 1'b0;
    endtask

    task automatic send_cmd(input logic [7:0] a, input logic [7:0] lo, input logic [7:0] hi, input bit track);
        cmd_t c;
        send_byte(a);
        send_byte(lo);
        send_byte(hi);
        c.addr = a[3:0];
        c.data = {hi, lo};
        if (track && a[7:4] == 4'h0) sb.push_back(c);
    endtask

    task automatic wait_count(input int n);
        int k;
        k = 0;
        while (int'(master_count_out) != n && k < 3000) begin
            @(posedge clk_in);
            #1;
            k++;
        end
        chk("wait_count", int'(master_count_out), n);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_count"}, int'(master_count_out), 0);
        chk({tag, "_valid"}, int'(wr_valid_out), 0);
        chk({tag, "_data"}, int'(wr_data_out), 0);
        chk({tag, "_addr"}, int'(wr_addr_out), 0);
        chk({tag, "_err"}, int'(err_out), 0);
        chk({tag, "_level"}, int'(fifo_level_out), 0);
        chk({tag, "_ready"}, int'(bus_ready_out), 1);
    endtask

    initial begin
        repeat (3) @(posedge clk_in);
        #1;
        chk_reset_values("rst");
        reset_in = 1'b0;
        chk("count_start", int'(master_count_out), 0);
        send_cmd(8'h00, 8'h34, 8'h12, 1'b1);
        wait_count(20);
        chk("t1_writes", n_wr, 1);
        chk("t1_first_cnt", last_wr_cnt, 12);
        wait_count(500);
        send_cmd(8'h05, 8'h80, 8'h00, 1'b1);
        wait_cycles(4);
        chk("t2_latency", last_wr_cyc - acc_cyc, 2);
        chk("t2_writes", n_wr, 2);
        wait_count(1021);
        wr_cnts.delete();
        saw_stall = 1'b0;
        max_level = 0;
        for (int i = 0; i < DEPTH + 1; i++) send_cmd(8'(i), 8'(8'h10 + i), 8'hA0, 1'b1);
        wait_count(30);
        chk("t3_stall", int'(saw_stall), 1);
        chk("t3_full_level", max_level, DEPTH);
        chk("t3_num_wr", wr_cnts.size(), DEPTH + 1);
        foreach (wr_cnts[i]) chk("t3_slot", wr_cnts[i], 12 + i);
        wait_count(100);
        nw0 = n_wr;
        send_cmd(8'h15, 8'hAA, 8'hBB, 1'b1);
        chk("t4_err", int'(err_out), 1);
        send_cmd(8'h08, 8'h03, 8'h00, 1'b1);
        wait_cycles(10);
        chk("t4_writes", n_wr - nw0, 1);
        chk("t4_err_sticky", int'(err_out), 1);
        chk("t4_level", int'(fifo_level_out), 0);
        wait_count(1021);
        nw0 = n_wr;
        send_cmd(8'h01, 8'h11, 8'h00, 1'b0);
        send_cmd(8'h02, 8'h22, 8'h00, 1'b0);
        send_byte(8'h03);
        send_byte(8'h33);
        chk("t5_level", int'(fifo_level_out), 2);
        reset_in = 1'b1;
        sb.delete();
        wait_cycles(2);
        chk_reset_values("t5_rst");
        reset_in = 1'b0;
        wait_cycles(1);
        chk("t5_count_run", int'(master_count_out), 1);
        wait_cycles(1100);
        chk("t5_no_writes", n_wr - nw0, 0);
        chk("t5_err_clear", int'(err_out), 0);
`ifdef CMD_TIMEOUT_EN
        nw0 = n_wr;
        send_byte(8'h02);
        wait_cycles(254);
        chk("to_err_early", int'(err_out), 0);
        wait_cycles(1);
        chk("to_err", int'(err_out), 1);
        send_cmd(8'h03, 8'h01, 8'h00, 1'b1);
        wait_cycles(1030);
        chk("to_writes", n_wr - nw0, 1);
`endif
        chk("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
